// File: rtl/wb_master_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_master_pkg
// Desc   : Shared constants for the Wishbone single-transfer initiator:
//          FSM encoding, default timeout, error data and peripheral map.
// Rev    : 1.0  initial release
// ============================================================================
package wb_master_pkg;

  localparam logic [1:0] c_state_idle = 2'd0;
  localparam logic [1:0] c_state_bus  = 2'd1;
  localparam logic [1:0] c_state_resp = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = c_state_idle,
    ST_BUS  = c_state_bus,
    ST_RESP = c_state_resp
  } state_t;

  localparam int          c_timeout_cycles_default = 255;
  localparam logic [31:0] c_err_data               = 32'h0000_0000;

  // Peripheral windows reachable from on-chip initiators
  localparam logic [31:0] c_periph_base_0 = 32'h3000_0000;
  localparam logic [31:0] c_periph_base_1 = 32'h3000_0100;
  localparam logic [31:0] c_periph_base_2 = 32'h3000_0200;
  localparam logic [31:0] c_periph_base_3 = 32'h3000_0300;
  localparam logic [31:0] c_periph_base_4 = 32'h3000_1000;
  localparam logic [31:0] c_periph_base_5 = 32'h3000_2000;

endpackage : wb_master_pkg
`default_nettype wire

// File: rtl/wb_master_timeout.sv
`default_nettype none
// ============================================================================
// Module : wb_master_timeout
// Desc   : Clear/enable counter that flags the last permitted wait cycle of a
//          Wishbone transfer (count == TIMEOUT_CYCLES-1).
// Rev    : 1.0  initial release
// ============================================================================
module wb_master_timeout #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [TO_W-1:0] c_limit = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expire = (r_count == c_limit);

endmodule : wb_master_timeout
`default_nettype wire

// File: rtl/wb_master_engine.sv
`default_nettype none
// ============================================================================
// Module : wb_master_engine
// Desc   : Wishbone classic initiator: one command in, one bus cycle, one
//          response out. Define WB_MASTER_TIMEOUT_EN to abort unACKed cycles.
// Rev    : 1.0  initial release
// ============================================================================
module wb_master_engine
  import wb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = c_timeout_cycles_default,
  parameter int TO_W           = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [3:0]  cmd_sel_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  // An illegal timeout configuration keeps the command port closed
  localparam logic c_cfg_ok = (TIMEOUT_CYCLES >= 1) && (TIMEOUT_CYCLES <= 65535) &&
                              (TO_W >= 1) && (TO_W <= 32) &&
                              (64'(TIMEOUT_CYCLES) < (64'd1 << TO_W));

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_cyc;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_dat;

  logic        w_cyc_nxt;
  logic        w_we_nxt;
  logic [3:0]  w_sel_nxt;
  logic [31:0] w_adr_nxt;
  logic [31:0] w_dat_nxt;
  logic        w_rsp_valid_nxt;
  logic        w_rsp_err_nxt;
  logic [31:0] w_rsp_dat_nxt;

  logic        w_accept;
  logic        w_expire;

  assign cmd_ready_o = (r_state == ST_IDLE) && c_cfg_ok;
  assign w_accept    = cmd_valid_i && cmd_ready_o;

`ifdef WB_MASTER_TIMEOUT_EN
  logic w_bus_wait;

  assign w_bus_wait = (r_state == ST_BUS) && !wbm_ack_i;

  wb_master_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_timeout (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .i_clear  (w_accept),
    .i_enable (w_bus_wait),
    .o_expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cyc_nxt       = r_cyc;
    w_we_nxt        = r_we;
    w_sel_nxt       = r_sel;
    w_adr_nxt       = r_adr;
    w_dat_nxt       = r_dat;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_err_nxt   = r_rsp_err;
    w_rsp_dat_nxt   = r_rsp_dat;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_we_nxt    = cmd_we_i;
          w_sel_nxt   = cmd_sel_i;
          w_adr_nxt   = cmd_adr_i;
          w_dat_nxt   = cmd_dat_i;
          w_cyc_nxt   = 1'b1;
          w_state_nxt = ST_BUS;
        end
      end
      ST_BUS: begin
        // ACK in the final permitted cycle takes priority over the timeout
        if (wbm_ack_i) begin
          w_cyc_nxt       = 1'b0;
          w_rsp_dat_nxt   = r_we ? c_err_data : wbm_dat_i;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = ST_RESP;
        end else if (w_expire) begin
          w_cyc_nxt       = 1'b0;
          w_rsp_dat_nxt   = c_err_data;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_cyc_nxt       = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_state_nxt     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= 4'h0;
      r_adr       <= 32'h0;
      r_dat       <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_dat   <= 32'h0;
    end else begin
      r_cyc       <= w_cyc_nxt;
      r_we        <= w_we_nxt;
      r_sel       <= w_sel_nxt;
      r_adr       <= w_adr_nxt;
      r_dat       <= w_dat_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_dat   <= w_rsp_dat_nxt;
    end
  end

  assign wbm_cyc_o   = r_cyc;
  assign wbm_stb_o   = r_cyc;
  assign wbm_we_o    = r_we;
  assign wbm_sel_o   = r_sel;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_dat;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o   = r_rsp_err;
  assign rsp_dat_o   = r_rsp_dat;

endmodule : wb_master_engine
`default_nettype wire
